// File: rtl/pc_branch_unit_pkg.sv
// Shared opcode map and width helper for the PC / branch-resolution unit.
package pc_branch_unit_pkg;

  localparam int OPC_B    = 8;
  localparam int OPC_BP   = 9;
  localparam int OPC_BN   = 10;
  localparam int OPC_BZ   = 11;
  localparam int OPC_CALL = 12;
  localparam int OPC_RET  = 13;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/pc_branch_unit_ret_addr_stack.sv
// Circular LIFO of return addresses.
// A push while full overwrites the oldest entry, because the write slot then aliases it.
module ret_addr_stack
  import pc_branch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_dat,
  output logic [W-1:0]             o_top,
  output logic [clog2(DEPTH):0]    o_cnt,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int SP_W  = clog2(DEPTH);
  localparam int CNT_W = SP_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [SP_W-1:0]  r_sp;
  logic [CNT_W-1:0] r_cnt;
  logic [SP_W-1:0]  w_sp_top;

  assign w_sp_top = r_sp - 1'b1;
  assign o_top    = r_mem[w_sp_top];
  assign o_cnt    = r_cnt;
  assign o_full   = (r_cnt == CNT_W'(DEPTH));
  assign o_empty  = (r_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sp  <= '0;
      r_cnt <= '0;
    end else if (i_push) begin
      r_sp <= r_sp + 1'b1;
      if (!o_full) r_cnt <= r_cnt + 1'b1;
    end else if (i_pop && !o_empty) begin
      r_sp  <= w_sp_top;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_sp] <= i_dat;
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter with PC-relative branches, absolute load and, under
// PC_BRANCH_RAS_EN, a return-address stack for CALL/RET. One-cycle latency.
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int PC_W      = 10,
  parameter int DATA_W    = 8,
  parameter int OFF_W     = 8,
  parameter int OPC_W     = 4,
  parameter int RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_pc,
  input  logic                       REPC,
  input  logic [OPC_W-1:0]           ir_opcode,
  input  logic [DATA_W-1:0]          R_val,
  input  logic [OFF_W-1:0]           ir_operand_addr,
  input  logic                       ld_en,
  input  logic [PC_W-1:0]            ld_addr,
  output logic [PC_W-1:0]            pc,
  output logic                       taken,
  output logic [clog2(RAS_DEPTH):0]  ras_cnt,
  output logic                       ras_ovf,
  output logic                       ras_unf
);

  localparam int EXT_W = (PC_W > OFF_W) ? PC_W : OFF_W;

  logic [PC_W-1:0]  r_pc;
  logic             r_taken;
  logic [EXT_W-1:0] w_off_ext;
  logic [PC_W-1:0]  w_off;
  logic [PC_W-1:0]  w_pc_seq;
  logic [PC_W-1:0]  w_pc_tgt;
  logic [PC_W-1:0]  w_pc_nxt;
  logic             w_redirect;
  logic             w_neg;
  logic             w_zero;

  // Sign-extend first, then truncate, so wide offsets still wrap modulo 2^PC_W.
  assign w_off_ext = EXT_W'($signed(ir_operand_addr));
  assign w_off     = w_off_ext[PC_W-1:0];
  assign w_pc_seq  = r_pc + PC_W'(1);
  assign w_pc_tgt  = r_pc + w_off;
  assign w_neg     = R_val[DATA_W-1];
  assign w_zero    = (R_val == '0);

`ifdef PC_BRANCH_RAS_EN
  logic                      w_push;
  logic                      w_pop;
  logic                      w_advance;
  logic                      w_full;
  logic                      w_empty;
  logic [PC_W-1:0]           w_ras_top;
  logic                      r_ovf;
  logic                      r_unf;

  assign w_advance = REPC && !ld_en;

  ret_addr_stack #(.DEPTH(RAS_DEPTH), .W(PC_W)) u_ras (
    .i_clk   (clk),
    .i_rst   (reset_pc),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_dat   (w_pc_seq),
    .o_top   (w_ras_top),
    .o_cnt   (ras_cnt),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset_pc) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_push && w_full) r_ovf <= 1'b1;
      if (w_advance && ir_opcode == OPC_W'(OPC_RET) && w_empty) r_unf <= 1'b1;
    end
  end

  assign ras_ovf = r_ovf;
  assign ras_unf = r_unf;
`else
  assign ras_cnt = '0;
  assign ras_ovf = 1'b0;
  assign ras_unf = 1'b0;
`endif

  always_comb begin
    w_pc_nxt   = w_pc_seq;
    w_redirect = 1'b0;
`ifdef PC_BRANCH_RAS_EN
    w_push     = 1'b0;
    w_pop      = 1'b0;
`endif
    case (ir_opcode)
      OPC_W'(OPC_B):  w_redirect = 1'b1;
      OPC_W'(OPC_BP): w_redirect = !w_neg;
      OPC_W'(OPC_BN): w_redirect = w_neg;
      OPC_W'(OPC_BZ): w_redirect = w_zero;
`ifdef PC_BRANCH_RAS_EN
      OPC_W'(OPC_CALL): begin
        w_redirect = 1'b1;
        w_push     = w_advance;
      end
      OPC_W'(OPC_RET): begin
        if (!w_empty) begin
          w_pc_nxt = w_ras_top;
          w_pop    = w_advance;
        end
      end
`endif
      default: w_redirect = 1'b0;
    endcase
    if (w_redirect) w_pc_nxt = w_pc_tgt;
`ifdef PC_BRANCH_RAS_EN
    if (ir_opcode == OPC_W'(OPC_RET) && !w_empty) w_redirect = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset_pc) begin
      r_pc    <= '0;
      r_taken <= 1'b0;
    end else if (ld_en) begin
      r_pc    <= ld_addr;
      r_taken <= 1'b1;
    end else if (REPC) begin
      r_pc    <= w_pc_nxt;
      r_taken <= w_redirect;
    end else begin
      r_taken <= 1'b0;
    end
  end

  assign pc    = r_pc;
  assign taken = r_taken;

endmodule
